// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI line-fill arbiter.
// Related build macro: QSPI_ARB_FIXED_PRIO_EN (consumed by qspi_rr_pick).
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int unsigned LINE_W_DEF = 128;
    localparam int unsigned ADDR_W_DEF = 32;

    // Low address bits dropped to align a byte address to a 16-byte line.
    localparam int unsigned LINE_OFS = 4;

endpackage

// File: rtl/qspi_rr_pick.sv
// Two-way grant picker for the QSPI fill arbiter.
// Default build: round-robin using the last-grant pointer.
// With QSPI_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie, pointer ignored.
module qspi_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       idx
);

`ifdef QSPI_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
`endif

    // Select the winning port index and its one-hot grant.
    always_comb begin
        idx   = 1'b0;
        grant = '0;
`ifdef QSPI_ARB_FIXED_PRIO_EN
        idx = ~req[0];
`else
        if (req == 2'b11) begin
            idx = ~last;
        end else begin
            idx = req[1];
        end
`endif
        if (|req) begin
            grant = idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/qspi_fill_arbiter.sv
// Arbitrates two line-fill requesters onto one QSPI read interface.
// Flow: IDLE (grant) -> ISSUE (start pulse) -> WAIT (data or timeout) -> RESP.
// Build macro QSPI_ARB_FIXED_PRIO_EN selects fixed priority inside qspi_rr_pick.
module qspi_fill_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned LINE_W  = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] qspi_addr,
    output logic              qspi_read_en,
    input  logic [LINE_W-1:0] qspi_dout,
    input  logic              qspi_dval,
    input  logic              qspi_rready
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [1:0]        pick_grant;
    logic              pick_idx;
    logic              last_grant;
    logic              grant_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic              err_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;

    qspi_rr_pick u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign sel_addr     = pick_idx ? req_addr1 : req_addr0;
    // Counter holds the number of WAIT cycles already completed, so the
    // current cycle is the TIMEOUT-th one when it reads TIMEOUT-1.
    assign tmo_hit      = (32'(tmo_cnt) + 32'd1) == 32'(TIMEOUT);
    assign busy         = (state != IDLE);
    assign qspi_addr    = addr_q;
    assign rsp_data     = data_q;
    assign rsp_err      = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        rsp_valid    = '0;
        qspi_read_en = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = pick_grant;
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (qspi_rready) begin
                    qspi_read_en = 1'b1;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (qspi_dval || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = grant_idx ? 2'b10 : 2'b01;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, address latch, timeout counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_idx  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            if (accept) begin
                last_grant <= pick_idx;
                grant_idx  <= pick_idx;
                addr_q     <= {sel_addr[ADDR_W-1:LINE_OFS], {LINE_OFS{1'b0}}};
            end
            if (state == ISSUE && qspi_rready) begin
                tmo_cnt <= '0;
            end
            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
                // Data beats a coincident timeout.
                if (qspi_dval) begin
                    data_q <= qspi_dout;
                    err_q  <= 1'b0;
                end else if (tmo_hit) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_fill_arbiter.sv
// Directed self-checking bench for qspi_fill_arbiter.
// Instance dut uses TIMEOUT=255; instance dut_t8 uses TIMEOUT=8 with its own
// request/dval inputs for the timeout cases.
module tb_qspi_fill_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_valid_b;
    logic [31:0]  req_addr0, req_addr1;
    logic [127:0] dout;
    logic         dval, dval_b, rready;

    logic [1:0]   req_ready, rsp_valid, req_ready_b, rsp_valid_b;
    logic [127:0] rsp_data, rsp_data_b;
    logic         rsp_err, busy, read_en, rsp_err_b, busy_b, read_en_b;
    logic [31:0]  qspi_addr, qspi_addr_b;

    int checks   = 0;
    int failures = 0;
    int exp_order [4];

    always #5 clk = ~clk;

    qspi_fill_arbiter #(.TIMEOUT(255), .ADDR_W(32), .LINE_W(128)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .qspi_addr(qspi_addr),
        .qspi_read_en(read_en), .qspi_dout(dout), .qspi_dval(dval),
        .qspi_rready(rready)
    );

    qspi_fill_arbiter #(.TIMEOUT(8), .ADDR_W(32), .LINE_W(128)) dut_t8 (
        .clk(clk), .rst(rst), .req_valid(req_valid_b),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .rsp_err(rsp_err_b), .busy(busy_b), .qspi_addr(qspi_addr_b),
        .qspi_read_en(read_en_b), .qspi_dout(dout), .qspi_dval(dval_b),
        .qspi_rready(rready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One fetch on the TIMEOUT=8 instance from port 1; dcyc is the WAIT cycle
    // (1-based) carrying dval, 0 for none.
    task automatic t8_fetch(input int dcyc, input logic [127:0] line,
                            input logic exp_err, input logic [127:0] exp_data);
        req_valid_b = 2'b10;
        #1 chk("t8_req_ready", req_ready_b, 2'b10);
        cyc();
        req_valid_b = 2'b00;
        #1 chk("t8_read_en", read_en_b, 1'b1);
        cyc();
        for (int c = 1; c <= 8; c++) begin
            dval_b = (c == dcyc);
            dout   = line;
            #1 chk("t8_wait_no_rsp", rsp_valid_b, 2'b00);
            cyc();
            if (c == dcyc) break;
        end
        dval_b = 1'b0;
        dout   = '1;
        #1;
        chk("t8_rsp_valid", rsp_valid_b, 2'b10);
        chk("t8_rsp_err", rsp_err_b, exp_err);
        chk("t8_rsp_data", rsp_data_b, exp_data);
        cyc();
        #1 chk("t8_idle", busy_b, 1'b0);
    endtask

    initial begin
        logic [127:0] ln;
        logic [1:0]   eg;
        logic [31:0]  ea;

`ifdef QSPI_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        rst = 1'b1; req_valid = '0; req_valid_b = '0;
        req_addr0 = 32'h0000_1237; req_addr1 = 32'hABCD_EF9F;
        dout = '0; dval = 1'b0; dval_b = 1'b0; rready = 1'b1;

        // Reset values
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_qspi_addr", qspi_addr, 32'h0);
        chk("rst_read_en", read_en, 1'b0);
        chk("rst_t8_busy", busy_b, 1'b0);

        // Contention: both ports hold requests for four fetches
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            eg = (exp_order[k] == 1) ? 2'b10 : 2'b01;
            ea = (exp_order[k] == 1) ? 32'hABCD_EF90 : 32'h0000_1230;
            ln = {4{32'hA5A5_0000 + 32'(k)}};
            #1 chk("cont_req_ready", req_ready, eg);
            cyc();
            #1;
            chk("cont_read_en", read_en, 1'b1);
            chk("cont_qspi_addr", qspi_addr, ea);
            cyc();
            dval = 1'b1; dout = ln;
            #1 chk("cont_busy_hold", req_ready, 2'b00);
            cyc();
            dval = 1'b0; dout = '0;
            #1;
            chk("cont_rsp_valid", rsp_valid, eg);
            chk("cont_rsp_data", rsp_data, ln);
            cyc();
        end
        req_valid = 2'b00;

        // Single request from port 0, dval ten cycles after read_en
        req_valid = 2'b01;
        #1 chk("single_req_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        #1;
        chk("single_read_en", read_en, 1'b1);
        chk("single_qspi_addr", qspi_addr, 32'h0000_1230);
        chk("single_busy", busy, 1'b1);
        cyc();
        for (int i = 1; i <= 9; i++) begin
            #1;
            chk("single_wait_read_en", read_en, 1'b0);
            chk("single_wait_rsp", rsp_valid, 2'b00);
            cyc();
        end
        dval = 1'b1; dout = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1;
        cyc();
        dval = 1'b0; dout = '0;
        #1;
        chk("single_rsp_valid", rsp_valid, 2'b01);
        chk("single_rsp_data", rsp_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("single_rsp_err", rsp_err, 1'b0);
        chk("single_addr_hold", qspi_addr, 32'h0000_1230);
        cyc();
        #1;
        chk("single_rsp_once", rsp_valid, 2'b00);
        chk("single_idle", busy, 1'b0);

        // Stray dval while idle
        dval = 1'b1; dout = '1;
        cyc();
        #1;
        chk("stray_rsp", rsp_valid, 2'b00);
        chk("stray_busy", busy, 1'b0);
        dval = 1'b0;
        cyc();
        #1 chk("stray_rsp2", rsp_valid, 2'b00);

        // Backpressure: rready low for five ISSUE cycles
        rready = 1'b0;
        req_valid = 2'b01;
        #1 chk("bp_req_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            #1 chk("bp_no_read_en", read_en, 1'b0);
            cyc();
        end
        rready = 1'b1;
        #1 chk("bp_read_en", read_en, 1'b1);
        cyc();
        #1 chk("bp_read_en_once", read_en, 1'b0);
        dval = 1'b1; dout = 128'hBEEF;
        cyc();
        dval = 1'b0;
        #1 chk("bp_rsp_valid", rsp_valid, 2'b01);
        cyc();

        // Reset while in WAIT after a port-0 grant
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("wrst_busy", busy, 1'b0);
        chk("wrst_rsp_valid", rsp_valid, 2'b00);
        chk("wrst_rsp_err", rsp_err, 1'b0);
        chk("wrst_rsp_data", rsp_data, 128'h0);
        chk("wrst_qspi_addr", qspi_addr, 32'h0);
        chk("wrst_read_en", read_en, 1'b0);
        cyc();
        #1 chk("wrst_no_rsp", rsp_valid, 2'b00);
        req_valid = 2'b11;
        #1 chk("wrst_port0_wins", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        cyc();
        dval = 1'b1; dout = 128'h77;
        cyc();
        dval = 1'b0;
        #1 chk("wrst_rsp_valid2", rsp_valid, 2'b01);
        cyc();

        // TIMEOUT=8 instance: normal fetch, pure timeout, then dval on the timeout cycle
        t8_fetch(3, 128'hCAFE_0001, 1'b0, 128'hCAFE_0001);
        t8_fetch(0, 128'hDEAD_0002, 1'b1, 128'h0);
        t8_fetch(8, 128'hF00D_0003, 1'b0, 128'hF00D_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
